// File: rtl/rvh_l1d_mshr_alloc_ctrl.sv
// L1D MSHR valid/line-address owner with round-robin allocation among miss requesters; optional RVH_L1D_MSHR_LOAD_RESERVE_EN keeps one entry for the load pipe.
// Latency: grant/conflict are combinational in the request cycle; mshr_valid_o and the free count update at the next clk edge.
// Backpressure: a requester holds its request until req_ready_o or req_conflict_o; no grants while full.
module rvh_l1d_mshr_alloc_ctrl #(
    parameter int N_MSHR      = 4,
    parameter int N_MSHR_W    = 2,
    parameter int N_REQ       = 2,
    parameter int N_REQ_W     = 1,
    parameter int LINE_ADDR_W = 34
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_REQ-1:0]                       req_valid_i,
    input  logic [N_REQ-1:0][LINE_ADDR_W-1:0]      req_line_addr_i,
    output logic [N_REQ-1:0]                       req_ready_o,
    output logic [N_REQ-1:0][N_MSHR_W-1:0]         req_mshr_id_o,
    output logic [N_REQ-1:0]                       req_conflict_o,
    input  logic                                   dealloc_valid_i,
    input  logic [N_MSHR_W-1:0]                    dealloc_id_i,
    output logic [N_MSHR-1:0]                      mshr_valid_o,
    output logic [N_MSHR_W:0]                      free_mshr_num_o,
    output logic                                   mshr_full_o
);

    localparam logic [N_MSHR_W:0] CNT_ONE = 1;

    logic [N_MSHR-1:0]                  valid_q, valid_d;
    logic [N_MSHR-1:0][LINE_ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [N_REQ_W-1:0]                 rr_ptr_q, rr_ptr_d;

    logic [N_MSHR_W:0]                  free_num;
    logic [N_MSHR_W-1:0]                free_id;
    logic [N_REQ-1:0]                   conflict;
    logic [N_REQ-1:0]                   eligible;
    logic [N_REQ-1:0][N_MSHR_W-1:0]     match_id;
    logic                               grant_vld;
    logic [N_REQ_W-1:0]                 grant_idx;
    logic [N_REQ_W-1:0]                 cand;

    // Descending scans so the lowest matching / free index is the one left standing.
    always_comb begin
        free_num = '0;
        free_id  = '0;
        for (int e = N_MSHR - 1; e >= 0; e--) begin
            if (!valid_q[e]) begin
                free_num = free_num + CNT_ONE;
                free_id  = N_MSHR_W'(e);
            end
        end
    end

    always_comb begin
        conflict = '0;
        match_id = '0;
        eligible = '0;
        for (int r = 0; r < N_REQ; r++) begin
            for (int e = N_MSHR - 1; e >= 0; e--) begin
                if (valid_q[e] && (line_addr_q[e] == req_line_addr_i[r])) begin
                    conflict[r] = req_valid_i[r];
                    match_id[r] = N_MSHR_W'(e);
                end
            end
`ifdef RVH_L1D_MSHR_LOAD_RESERVE_EN
            eligible[r] = req_valid_i[r] && !conflict[r] &&
                          ((r == 0) ? (free_num != '0) : (free_num > CNT_ONE));
`else
            eligible[r] = req_valid_i[r] && !conflict[r] && (free_num != '0);
`endif
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = N_REQ_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready_o    = '0;
        req_conflict_o = '0;
        req_mshr_id_o  = '0;
        for (int r = 0; r < N_REQ; r++) begin
            req_ready_o[r]    = rst_n && grant_vld && (grant_idx == N_REQ_W'(r));
            req_conflict_o[r] = rst_n && conflict[r];
            if (conflict[r]) begin
                req_mshr_id_o[r] = match_id[r];
            end else if (req_ready_o[r]) begin
                req_mshr_id_o[r] = free_id;
            end
        end
    end

    // Allocation targets an entry that is invalid in registered state, so it never collides with the dealloc index.
    always_comb begin
        valid_d     = valid_q;
        line_addr_d = line_addr_q;
        rr_ptr_d    = rr_ptr_q;
        if (dealloc_valid_i) begin
            valid_d[dealloc_id_i] = 1'b0;
        end
        if (grant_vld) begin
            valid_d[free_id]     = 1'b1;
            line_addr_d[free_id] = req_line_addr_i[grant_idx];
            if (int'(grant_idx) == N_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + N_REQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            line_addr_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            line_addr_q <= line_addr_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign mshr_valid_o    = valid_q;
    assign free_mshr_num_o = free_num;
    assign mshr_full_o     = (free_num == '0);

    a_dealloc_live: assert property (@(posedge clk) disable iff (!rst_n)
        dealloc_valid_i |-> valid_q[dealloc_id_i]);

endmodule
